// File: rtl/digit_serial_add_sub.sv
// Digit-serial adder/subtractor: N-bit operands handled K bits per clock with the
// carry/borrow held in a register between digits, plus start/busy/done handshake.
module digit_serial_add_sub #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_mode,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_result,
  output logic         o_carry,
  output logic         o_overflow,
  output logic         o_zero
);

  localparam int D  = N / K;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam logic [IW-1:0] LAST = IW'(D - 1);

  generate
    if (N < 1 || K < 1 || K > N || (N % K) != 0) begin : g_bad_params
      $error("digit_serial_add_sub: need 1 <= K <= N and N %% K == 0");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           mode_q, mode_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   b_q, b_d;
  logic           a_sign_q, a_sign_d;
  logic           b_sign_q, b_sign_d;
  logic [N-1:0]   acc_q, acc_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [N-1:0]   result_q, result_d;
  logic           carry_out_q, carry_out_d;
  logic           overflow_q, overflow_d;
  logic           zero_q, zero_d;

  logic [K:0]     digit;
  logic [N+K-1:0] acc_cat;

  // Operands shift right one digit per RUN cycle so the low digit is always at
  // bit 0; the accumulator fills from the top and is complete after D shifts.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;
    a_sign_d    = a_sign_q;
    b_sign_d    = b_sign_q;
    acc_d       = acc_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;

    if (mode_q)
      digit = {1'b0, a_q[K-1:0]} + {1'b0, b_q[K-1:0]} + {{K{1'b0}}, carry_q};
    else
      digit = {1'b0, a_q[K-1:0]} - {1'b0, b_q[K-1:0]} - {{K{1'b0}}, carry_q};
    acc_cat = {digit[K-1:0], acc_q};

    case (state_q)
      IDLE, DONE: begin
        if (i_start) begin
          state_d  = RUN;
          idx_d    = '0;
          carry_d  = 1'b0;
          mode_d   = i_mode;
          a_d      = i_a;
          b_d      = i_b;
          a_sign_d = i_a[N-1];
          b_sign_d = i_b[N-1];
          acc_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d   = acc_cat[N+K-1:K];
        carry_d = digit[K];
        a_d     = a_q >> K;
        b_d     = b_q >> K;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d     = DONE;
          result_d    = acc_d;
          carry_out_d = digit[K];
          zero_d      = (acc_d == '0);
          if (mode_q)
            overflow_d = (a_sign_q == b_sign_q) && (acc_d[N-1] != a_sign_q);
          else
            overflow_d = (a_sign_q != b_sign_q) && (acc_d[N-1] != a_sign_q);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      mode_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      a_sign_q    <= 1'b0;
      b_sign_q    <= 1'b0;
      acc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      mode_q      <= mode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      a_sign_q    <= a_sign_d;
      b_sign_q    <= b_sign_d;
      acc_q       <= acc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_result   = result_q;
  assign o_carry    = carry_out_q;
  assign o_overflow = overflow_q;
  assign o_zero     = zero_q;

endmodule

// File: tb/tb_digit_serial_add_sub.sv
// Testbench for digit_serial_add_sub: four instances (K = 1, 2, 4, 8 at N = 8) share
// stimulus; directed tests use the K = 4 instance, the sweep checks all four.
module tb_digit_serial_add_sub;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic       i_mode = 1'b0;
  logic [7:0] i_a = '0;
  logic [7:0] i_b = '0;

  logic       busy_w [4];
  logic       done_w [4];
  logic [7:0] result_w [4];
  logic       carry_w [4];
  logic       ovf_w [4];
  logic       zero_w [4];

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  digit_serial_add_sub #(.N(8), .K(1)) u_k1 (.i_clock(clk), .i_reset(i_reset), .i_start(i_start),
    .i_mode(i_mode), .i_a(i_a), .i_b(i_b), .o_busy(busy_w[0]), .o_done(done_w[0]),
    .o_result(result_w[0]), .o_carry(carry_w[0]), .o_overflow(ovf_w[0]), .o_zero(zero_w[0]));
  digit_serial_add_sub #(.N(8), .K(2)) u_k2 (.i_clock(clk), .i_reset(i_reset), .i_start(i_start),
    .i_mode(i_mode), .i_a(i_a), .i_b(i_b), .o_busy(busy_w[1]), .o_done(done_w[1]),
    .o_result(result_w[1]), .o_carry(carry_w[1]), .o_overflow(ovf_w[1]), .o_zero(zero_w[1]));
  digit_serial_add_sub #(.N(8), .K(4)) u_k4 (.i_clock(clk), .i_reset(i_reset), .i_start(i_start),
    .i_mode(i_mode), .i_a(i_a), .i_b(i_b), .o_busy(busy_w[2]), .o_done(done_w[2]),
    .o_result(result_w[2]), .o_carry(carry_w[2]), .o_overflow(ovf_w[2]), .o_zero(zero_w[2]));
  digit_serial_add_sub #(.N(8), .K(8)) u_k8 (.i_clock(clk), .i_reset(i_reset), .i_start(i_start),
    .i_mode(i_mode), .i_a(i_a), .i_b(i_b), .o_busy(busy_w[3]), .o_done(done_w[3]),
    .o_result(result_w[3]), .o_carry(carry_w[3]), .o_overflow(ovf_w[3]), .o_zero(zero_w[3]));

  // Advance past the next rising edge; inputs are driven and outputs sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: whole-word unsigned and signed arithmetic, no digit decomposition.
  function automatic void model(input logic mode, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic c, output logic v,
                                output logic z);
    int ua = int'(a);
    int ub = int'(b);
    int sa = int'($signed(a));
    int sb = int'($signed(b));
    int s;
    if (mode) begin
      r = 8'(ua + ub);
      c = (ua + ub) > 255;
      s = sa + sb;
    end else begin
      r = 8'(ua - ub);
      c = ua < ub;
      s = sa - sb;
    end
    v = (s > 127) || (s < -128);
    z = (r == 8'h00);
  endfunction

  // Launch one operation on all instances; lat = edges after the start edge until
  // the K=4 instance shows o_done (expected D = 2).
  task automatic do_op(input logic mode, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output logic busy_after_start);
    i_mode  = mode;
    i_a     = a;
    i_b     = b;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    busy_after_start = busy_w[2];
    lat = 0;
    while (!done_w[2] && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    step();
    step();
    i_reset = 1'b0;
    n_checks += 6;
    if (busy_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy got %b want 0", busy_w[2]); end
    if (done_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_done got %b want 0", done_w[2]); end
    if (result_w[2] !== 8'h00) begin n_fails++; $display("[TB] FAIL reset_result got %h want 00", result_w[2]); end
    if (carry_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_carry got %b want 0", carry_w[2]); end
    if (ovf_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_ovf got %b want 0", ovf_w[2]); end
    if (zero_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_zero got %b want 0", zero_w[2]); end
  endtask

  task automatic test_subtract();
    int   lat;
    logic b0;
    do_op(1'b0, 8'h35, 8'h17, lat, b0);
    n_checks += 8;
    if (b0 !== 1'b1) begin n_fails++; $display("[TB] FAIL sub1_busy got %b want 1", b0); end
    if (lat !== 2) begin n_fails++; $display("[TB] FAIL sub1_latency got %0d want 2", lat); end
    if (busy_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL sub1_busy_in_done got %b want 0", busy_w[2]); end
    if (result_w[2] !== 8'h1E) begin n_fails++; $display("[TB] FAIL sub1_result got %h want 1e", result_w[2]); end
    if (carry_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL sub1_carry got %b want 0", carry_w[2]); end
    if (ovf_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL sub1_ovf got %b want 0", ovf_w[2]); end
    if (zero_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL sub1_zero got %b want 0", zero_w[2]); end
    step();
    if (done_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL sub1_done_pulse got %b want 0", done_w[2]); end

    do_op(1'b0, 8'h17, 8'h35, lat, b0);
    n_checks += 2;
    if (result_w[2] !== 8'hE2) begin n_fails++; $display("[TB] FAIL sub2_result got %h want e2", result_w[2]); end
    if (carry_w[2] !== 1'b1) begin n_fails++; $display("[TB] FAIL sub2_borrow got %b want 1", carry_w[2]); end
    step();

    do_op(1'b0, 8'h80, 8'h01, lat, b0);
    n_checks += 3;
    if (result_w[2] !== 8'h7F) begin n_fails++; $display("[TB] FAIL sub3_result got %h want 7f", result_w[2]); end
    if (ovf_w[2] !== 1'b1) begin n_fails++; $display("[TB] FAIL sub3_ovf got %b want 1", ovf_w[2]); end
    if (carry_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL sub3_borrow got %b want 0", carry_w[2]); end
    step();
  endtask

  task automatic test_add();
    int   lat;
    logic b0;
    do_op(1'b1, 8'hFF, 8'h01, lat, b0);
    n_checks += 4;
    if (result_w[2] !== 8'h00) begin n_fails++; $display("[TB] FAIL add1_result got %h want 00", result_w[2]); end
    if (carry_w[2] !== 1'b1) begin n_fails++; $display("[TB] FAIL add1_carry got %b want 1", carry_w[2]); end
    if (zero_w[2] !== 1'b1) begin n_fails++; $display("[TB] FAIL add1_zero got %b want 1", zero_w[2]); end
    if (ovf_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL add1_ovf got %b want 0", ovf_w[2]); end
    step();

    do_op(1'b1, 8'h7F, 8'h01, lat, b0);
    n_checks += 4;
    if (result_w[2] !== 8'h80) begin n_fails++; $display("[TB] FAIL add2_result got %h want 80", result_w[2]); end
    if (ovf_w[2] !== 1'b1) begin n_fails++; $display("[TB] FAIL add2_ovf got %b want 1", ovf_w[2]); end
    if (carry_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL add2_carry got %b want 0", carry_w[2]); end
    if (zero_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL add2_zero got %b want 0", zero_w[2]); end
    step();
  endtask

  task automatic test_back_to_back();
    int k;
    i_mode  = 1'b0;
    i_a     = 8'h35;
    i_b     = 8'h17;
    i_start = 1'b1;
    step();
    i_mode  = 1'b1;
    i_a     = 8'hAA;
    i_b     = 8'h01;
    step();
    i_start = 1'b0;
    i_a     = 8'hC3;
    i_b     = 8'h5A;
    k = 1;
    while (!done_w[2] && k < 20) begin
      step();
      k++;
    end
    n_checks += 3;
    if (k !== 2) begin n_fails++; $display("[TB] FAIL b2b_first_latency got %0d want 2", k); end
    if (result_w[2] !== 8'h1E) begin n_fails++; $display("[TB] FAIL b2b_ignored_start got %h want 1e", result_w[2]); end
    if (carry_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL b2b_first_carry got %b want 0", carry_w[2]); end

    i_mode  = 1'b0;
    i_a     = 8'h10;
    i_b     = 8'h10;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    n_checks += 1;
    if (busy_w[2] !== 1'b1) begin n_fails++; $display("[TB] FAIL b2b_no_gap_busy got %b want 1", busy_w[2]); end
    k = 0;
    while (!done_w[2] && k < 20) begin
      step();
      k++;
    end
    n_checks += 3;
    if (k !== 2) begin n_fails++; $display("[TB] FAIL b2b_second_latency got %0d want 2", k); end
    if (result_w[2] !== 8'h00) begin n_fails++; $display("[TB] FAIL b2b_second_result got %h want 00", result_w[2]); end
    if (zero_w[2] !== 1'b1) begin n_fails++; $display("[TB] FAIL b2b_second_zero got %b want 1", zero_w[2]); end
    step();
  endtask

  task automatic test_reset_abort();
    int   lat;
    int   dones;
    logic b0;
    do_op(1'b1, 8'hFF, 8'h01, lat, b0);
    step();
    i_mode  = 1'b0;
    i_a     = 8'h35;
    i_b     = 8'h17;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    n_checks += 6;
    if (busy_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL abort_busy got %b want 0", busy_w[2]); end
    if (done_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL abort_done got %b want 0", done_w[2]); end
    if (result_w[2] !== 8'h00) begin n_fails++; $display("[TB] FAIL abort_result got %h want 00", result_w[2]); end
    if (carry_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL abort_carry got %b want 0", carry_w[2]); end
    if (ovf_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL abort_ovf got %b want 0", ovf_w[2]); end
    if (zero_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL abort_zero got %b want 0", zero_w[2]); end
    dones = 0;
    for (int t = 0; t < 6; t++) begin
      step();
      if (done_w[2]) dones++;
    end
    n_checks += 1;
    if (dones !== 0) begin n_fails++; $display("[TB] FAIL abort_done_pulses got %0d want 0", dones); end

    do_op(1'b0, 8'h80, 8'h01, lat, b0);
    n_checks += 4;
    if (lat !== 2) begin n_fails++; $display("[TB] FAIL post_abort_latency got %0d want 2", lat); end
    if (result_w[2] !== 8'h7F) begin n_fails++; $display("[TB] FAIL post_abort_result got %h want 7f", result_w[2]); end
    if (ovf_w[2] !== 1'b1) begin n_fails++; $display("[TB] FAIL post_abort_ovf got %b want 1", ovf_w[2]); end
    if (carry_w[2] !== 1'b0) begin n_fails++; $display("[TB] FAIL post_abort_carry got %b want 0", carry_w[2]); end
    step();
  endtask

  task automatic test_k_sweep();
    int         exp_lat [4] = '{8, 4, 2, 1};
    int         cap_lat [4];
    logic [7:0] cap_r [4];
    logic       cap_c [4];
    logic       cap_v [4];
    logic       cap_z [4];
    logic [7:0] er;
    logic       ec, ev, ez;
    logic       m;
    logic [7:0] a, b;

    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    step();
    for (int it = 0; it < 24; it++) begin
      m = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      b = 8'($urandom);
      if (it == 0) begin m = 1'b1; a = 8'h80; b = 8'h80; end
      if (it == 1) begin m = 1'b0; a = 8'h00; b = 8'hFF; end
      model(m, a, b, er, ec, ev, ez);
      for (int i = 0; i < 4; i++) cap_lat[i] = -1;
      i_mode  = m;
      i_a     = a;
      i_b     = b;
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      i_a     = ~a;
      i_b     = ~b;
      for (int t = 1; t <= 12; t++) begin
        step();
        for (int i = 0; i < 4; i++) begin
          if (done_w[i] && cap_lat[i] < 0) begin
            cap_lat[i] = t;
            cap_r[i]   = result_w[i];
            cap_c[i]   = carry_w[i];
            cap_v[i]   = ovf_w[i];
            cap_z[i]   = zero_w[i];
          end
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_checks += 5;
        if (cap_lat[i] !== exp_lat[i]) begin n_fails++; $display("[TB] FAIL sweep_latency inst %0d op %0d got %0d want %0d", i, it, cap_lat[i], exp_lat[i]); end
        if (cap_r[i] !== er) begin n_fails++; $display("[TB] FAIL sweep_result inst %0d m=%b a=%h b=%h got %h want %h", i, m, a, b, cap_r[i], er); end
        if (cap_c[i] !== ec) begin n_fails++; $display("[TB] FAIL sweep_carry inst %0d m=%b a=%h b=%h got %b want %b", i, m, a, b, cap_c[i], ec); end
        if (cap_v[i] !== ev) begin n_fails++; $display("[TB] FAIL sweep_ovf inst %0d m=%b a=%h b=%h got %b want %b", i, m, a, b, cap_v[i], ev); end
        if (cap_z[i] !== ez) begin n_fails++; $display("[TB] FAIL sweep_zero inst %0d m=%b a=%h b=%h got %b want %b", i, m, a, b, cap_z[i], ez); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_subtract();
    test_add();
    test_back_to_back();
    test_reset_abort();
    test_k_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/digit_serial_add_sub.md
# digit_serial_add_sub

Multi-cycle, parametrised adder/subtractor that processes N-bit operands K bits per clock, rippling carry/borrow between digits through a register rather than a combinational chain. It succeeds the single-cycle ripple subtractor in designs where a long carry chain limits clock frequency. It adds an add/subtract mode, a start/busy/done handshake, and carry/borrow, signed-overflow and zero flags. It sits between the register file and the ALU result mux.

## Interface

- N, default 8, operand and result width in bits; N ≥ 1.
- K, default 4, digit width processed per cycle; 1 ≤ K ≤ N; N % K == 0, otherwise elaboration error.

- i_clock  input  1  single clock; all state on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_start  input  1  request a new operation; sampled only when not busy.
- i_mode  input  1  0 = subtract (i_a − i_b), 1 = add (i_a + i_b); latched with i_start.
- i_a  input  N  minuend / augend; latched with i_start.
- i_b  input  N  subtrahend / addend; latched with i_start.
- o_busy  output  1  high while digits are being processed.
- o_done  output  1  one-cycle pulse: result and flags valid.
- o_result  output  N  difference or sum, held until the next completion.
- o_carry  output  1  subtract: borrow out (1 iff unsigned i_a < i_b); add: carry out.
- o_overflow  output  1  two's-complement signed overflow.
- o_zero  output  1  o_result == 0.

## Operation

- States: IDLE, RUN, DONE. D = N/K digits.
- Reset (sampled high at any edge, any state): state → IDLE, digit index → 0, internal carry → 0, all outputs → 0. An operation in progress is aborted with no o_done.
- IDLE: on i_start = 1, latch i_a, i_b and i_mode, clear the digit index and the carry register, then go to RUN.
- RUN: on each edge, process digit j = index (bits j·K+K−1 : j·K).
  - Subtract: d = a_j − b_j − c, where c is the borrow.
  - Add: d = a_j + b_j + c, where c is the carry.
  - The digit result goes into an internal accumulator at position j. The carry register takes the digit's borrow or carry out. Index increments.
  - On processing digit D−1, go to DONE and load the outputs:
    - o_result ← accumulator including digit D−1.
    - o_carry ← final borrow/carry.
    - o_zero ← (o_result == 0).
    - o_overflow, subtract: (a[N−1] ≠ b[N−1]) and (r[N−1] ≠ a[N−1]).
    - o_overflow, add: (a[N−1] == b[N−1]) and (r[N−1] ≠ a[N−1]).
- DONE: o_done = 1 for exactly this cycle.
  - If i_start = 1, latch new operands and go to RUN; this is back-to-back operation.
  - Otherwise go to IDLE.
- i_start while in RUN is ignored. Latched operands are unaffected by input changes after the start edge.
- o_result and the flags change only on the edge that enters DONE, or on reset. They hold their values through IDLE and through the following operation's RUN.
- All arithmetic is modulo 2^N; there is no saturation.
- K = N degenerates to one RUN cycle. K = 1 is fully bit-serial.

## Timing

- i_start is sampled at edge E0. o_busy = 1 from after E0 until after edge E0+D.
- o_done = 1 and results are valid in the cycle after edge E0+D. Latency is D+1 edges from start to the done cycle's end.
- o_busy = 0 in DONE and IDLE. o_busy and o_done are never high together.
- Back-to-back throughput: one result per D+1 cycles.
- o_busy = 1 during RUN; otherwise o_busy = 0.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan

- N=8, K=4, subtract 0x35 − 0x17 → o_done 3 cycles after start, o_result 0x1E, o_carry 0, o_overflow 0, o_zero 0.
- N=8, K=4, subtract 0x17 − 0x35 → o_result 0xE2, o_carry 1. Then subtract 0x80 − 0x01 → 0x7F, o_overflow 1, o_carry 0.
- N=8, K=4, add 0xFF + 0x01 → 0x00, o_carry 1, o_zero 1, o_overflow 0. Then add 0x7F + 0x01 → 0x80, o_overflow 1, o_carry 0.
- Start 0x35 − 0x17; one cycle later pulse i_start with 0xAA/0x01 and change i_a/i_b → ignored, result 0x1E. Then assert i_start in the DONE cycle with 0x10 − 0x10 → no idle gap, next o_done after D+1 cycles, o_result 0x00, o_zero 1.
- Reset asserted in the 2nd RUN cycle → next cycle o_busy 0, o_done never pulses, o_result 0, all flags 0. A subsequent normal operation is correct.
- Sweep K ∈ {1, 2, 4, 8} with N=8 and random operands in both modes → matches a reference model for result, carry, overflow and zero, with latency D+1.
